// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared widths and Bayer matrix for the VGA dither output stage
//
// Contents:
//   IN_W      renderer colour width per channel
//   OUT_W     VGA DAC colour width per channel
//   POS_W     pixel row/column counter width
//   BAYER_4X4 4x4 ordered-dither threshold matrix, indexed [row][col]
package vga_pkg;

    localparam int IN_W  = 8;
    localparam int OUT_W = 3;
    localparam int POS_W = 10;

    localparam logic [3:0] BAYER_4X4 [0:3][0:3] = '{
        '{4'd0,  4'd8,  4'd2,  4'd10},
        '{4'd12, 4'd4,  4'd14, 4'd6},
        '{4'd3,  4'd11, 4'd1,  4'd9},
        '{4'd15, 4'd7,  4'd13, 4'd5}
    };

endpackage

// File: rtl/dither_quantize.sv
// rtl/dither_quantize.sv - combinational 8->3 bit colour quantiser with ordered dither
//
// Ports:
//   c        in   IN_W   colour channel value
//   b        in   4      Bayer threshold for this pixel
//   en       in   1      1 = add dither before truncation, 0 = plain truncation
//   visible  in   1      0 forces the output to black
//   q        out  OUT_W  quantised channel
module dither_quantize
    import vga_pkg::*;
(
    input  logic [IN_W-1:0]  c,
    input  logic [3:0]       b,
    input  logic             en,
    input  logic             visible,
    output logic [OUT_W-1:0] q
);

    // Threshold is scaled by 2 so the 16 matrix levels span one 32-code output step.
    logic [IN_W:0] sum;

    assign sum = {1'b0, c} + {4'b0000, b, 1'b0};

    always_comb begin
        q = '0;
        if (!visible) begin
            q = '0;
        end else if (!en) begin
            q = c[IN_W-1 -: OUT_W];
        end else if (sum[IN_W]) begin
            // Bright colours would otherwise wrap to black.
            q = '1;
        end else begin
            q = sum[IN_W-1 -: OUT_W];
        end
    end

endmodule

// File: rtl/vga_dither_output.sv
// rtl/vga_dither_output.sv - two-stage VGA output pipeline with 4x4 ordered dither and blanking
//
// Ports:
//   i_clk, i_rst_n               pixel clock, async active-low reset
//   i_hsync, i_vsync             syncs from the sync generator
//   i_vblank                     vertical blank, rising edge starts a new frame
//   i_visible                    pixel lies in the active area
//   i_hpos, i_vpos               pixel column / row
//   i_r, i_g, i_b                renderer colour, 8 bits per channel
//   i_dither_en                  1 = dither, 0 = truncate to [7:5]
//   o_vga_hsync, o_vga_vsync     syncs delayed to match the colour path
//   o_vga_r, o_vga_g, o_vga_b    quantised colour, 3 bits per channel
module vga_dither_output
    import vga_pkg::*;
#(
    parameter int   TEMPORAL  = 1,
    parameter logic SYNC_IDLE = 1'b1,
    parameter int   LATENCY   = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_hsync,
    input  logic             i_vsync,
    input  logic             i_vblank,
    input  logic             i_visible,
    input  logic [POS_W-1:0] i_hpos,
    input  logic [POS_W-1:0] i_vpos,
    input  logic [IN_W-1:0]  i_r,
    input  logic [IN_W-1:0]  i_g,
    input  logic [IN_W-1:0]  i_b,
    input  logic             i_dither_en,
    output logic             o_vga_hsync,
    output logic             o_vga_vsync,
    output logic [OUT_W-1:0] o_vga_r,
    output logic [OUT_W-1:0] o_vga_g,
    output logic [OUT_W-1:0] o_vga_b
);

    // The pipeline below is hard-wired to two register stages.
    if (LATENCY != 2) begin : g_latency_check
        $error("vga_dither_output: LATENCY must be 2");
    end

    // Frame offset: rotates the matrix diagonally once per frame so the
    // dither pattern does not sit still on static images.
    logic       vblank_d;
    logic [1:0] frame_ofs;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vblank_d  <= 1'b0;
            frame_ofs <= 2'd0;
        end else begin
            vblank_d <= i_vblank;
            if ((TEMPORAL != 0) && i_vblank && !vblank_d) begin
                frame_ofs <= frame_ofs + 2'd1;
            end
        end
    end

    // Stage 1: matrix lookup plus registered copies of everything that
    // must stay aligned with it.
    logic [1:0] mat_row;
    logic [1:0] mat_col;

    assign mat_row = i_vpos[1:0] + frame_ofs;
    assign mat_col = i_hpos[1:0] + frame_ofs;

    logic            s1_hsync;
    logic            s1_vsync;
    logic            s1_visible;
    logic            s1_dither_en;
    logic [IN_W-1:0] s1_r;
    logic [IN_W-1:0] s1_g;
    logic [IN_W-1:0] s1_b;
    logic [3:0]      s1_thresh;

    // Stage-1 syncs reset to the idle level too, so no active sync pulse
    // leaks out in the first clock after reset release.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_hsync     <= SYNC_IDLE;
            s1_vsync     <= SYNC_IDLE;
            s1_visible   <= 1'b0;
            s1_dither_en <= 1'b0;
            s1_r         <= '0;
            s1_g         <= '0;
            s1_b         <= '0;
            s1_thresh    <= '0;
        end else begin
            s1_hsync     <= i_hsync;
            s1_vsync     <= i_vsync;
            s1_visible   <= i_visible;
            s1_dither_en <= i_dither_en;
            s1_r         <= i_r;
            s1_g         <= i_g;
            s1_b         <= i_b;
            s1_thresh    <= BAYER_4X4[mat_row][mat_col];
        end
    end

    // Stage 2: quantise and register straight onto the pins.
    logic [OUT_W-1:0] q_r;
    logic [OUT_W-1:0] q_g;
    logic [OUT_W-1:0] q_b;

    dither_quantize u_quant_r (
        .c       (s1_r),
        .b       (s1_thresh),
        .en      (s1_dither_en),
        .visible (s1_visible),
        .q       (q_r)
    );

    dither_quantize u_quant_g (
        .c       (s1_g),
        .b       (s1_thresh),
        .en      (s1_dither_en),
        .visible (s1_visible),
        .q       (q_g)
    );

    dither_quantize u_quant_b (
        .c       (s1_b),
        .b       (s1_thresh),
        .en      (s1_dither_en),
        .visible (s1_visible),
        .q       (q_b)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_vga_hsync <= SYNC_IDLE;
            o_vga_vsync <= SYNC_IDLE;
            o_vga_r     <= '0;
            o_vga_g     <= '0;
            o_vga_b     <= '0;
        end else begin
            o_vga_hsync <= s1_hsync;
            o_vga_vsync <= s1_vsync;
            o_vga_r     <= q_r;
            o_vga_g     <= q_g;
            o_vga_b     <= q_b;
        end
    end

endmodule

// File: tb/tb_vga_dither_output.sv
// tb/tb_vga_dither_output.sv - directed vector bench for vga_dither_output
module tb_vga_dither_output;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       hsync, vsync, vblank, visible, dither_en;
    logic [9:0] hpos, vpos;
    logic [7:0] r, g, b;

    logic       f_hs, f_vs, t_hs, t_vs;
    logic [2:0] f_r, f_g, f_b, t_r, t_g, t_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Fixed-matrix instance
    vga_dither_output #(.TEMPORAL(0), .SYNC_IDLE(1'b1), .LATENCY(2)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_hsync(hsync), .i_vsync(vsync),
        .i_vblank(vblank), .i_visible(visible), .i_hpos(hpos), .i_vpos(vpos),
        .i_r(r), .i_g(g), .i_b(b), .i_dither_en(dither_en),
        .o_vga_hsync(f_hs), .o_vga_vsync(f_vs),
        .o_vga_r(f_r), .o_vga_g(f_g), .o_vga_b(f_b)
    );

    // Temporal instance, same stimulus
    vga_dither_output #(.TEMPORAL(1), .SYNC_IDLE(1'b1), .LATENCY(2)) dut_t (
        .i_clk(clk), .i_rst_n(rst_n), .i_hsync(hsync), .i_vsync(vsync),
        .i_vblank(vblank), .i_visible(visible), .i_hpos(hpos), .i_vpos(vpos),
        .i_r(r), .i_g(g), .i_b(b), .i_dither_en(dither_en),
        .o_vga_hsync(t_hs), .o_vga_vsync(t_vs),
        .o_vga_r(t_r), .o_vga_g(t_g), .o_vga_b(t_b)
    );

    typedef struct {
        logic       hs, vs, vis, en;
        logic [9:0] hpos, vpos;
        logic [7:0] r, g, b;
        logic [2:0] er, eg, eb;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic hs, input logic vs, input logic vis, input logic en,
                         input logic [9:0] hp, input logic [9:0] vp,
                         input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb);
        hsync = hs; vsync = vs; visible = vis; dither_en = en;
        hpos = hp; vpos = vp; r = rr; g = gg; b = bb;
    endtask

    task automatic vblank_pulse();
        vblank = 1'b1;
        @(negedge clk);
        vblank = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        //           hs    vs    vis   en    hpos     vpos     r      g      b      er    eg    eb
        vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 10'd0,   10'd0,   8'hA0, 8'h5F, 8'hFF, 3'd5, 3'd2, 3'd7};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 10'd0,   10'd0,   8'hBF, 8'h00, 8'h20, 3'd5, 3'd0, 3'd1};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 10'd3,   10'd3,   8'hBF, 8'hF6, 8'h00, 3'd6, 3'd7, 3'd0};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 10'd0,   10'd3,   8'hFF, 8'hE1, 8'hE2, 3'd7, 3'd7, 3'd7};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 10'd0,   10'd3,   8'hFF, 8'hFF, 8'hFF, 3'd0, 3'd0, 3'd0};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 10'd5,   10'd9,   8'hFF, 8'hFF, 8'hFF, 3'd0, 3'd0, 3'd0};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 10'd1,   10'd2,   8'h09, 8'h0A, 8'h7F, 3'd0, 3'd1, 3'd4};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 10'h3FE, 10'h3FD, 8'h64, 8'h63, 8'hE4, 3'd4, 3'd3, 3'd7};
        vecs[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 10'h3FE, 10'h3FD, 8'h64, 8'h63, 8'hE4, 3'd3, 3'd3, 3'd7};

        rst_n  = 1'b0;
        vblank = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 10'd0, 10'd0, 8'hFF, 8'hFF, 8'hFF);
        repeat (3) @(negedge clk);

        check("reset_r",     f_r,  0);
        check("reset_g",     f_g,  0);
        check("reset_b",     f_b,  0);
        check("reset_hsync", f_hs, 1);
        check("reset_vsync", f_vs, 1);

        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].hs, vecs[i].vs, vecs[i].vis, vecs[i].en,
                  vecs[i].hpos, vecs[i].vpos, vecs[i].r, vecs[i].g, vecs[i].b);
            repeat (2) @(negedge clk);
            check($sformatf("vec%0d_r", i),  f_r,  vecs[i].er);
            check($sformatf("vec%0d_g", i),  f_g,  vecs[i].eg);
            check($sformatf("vec%0d_b", i),  f_b,  vecs[i].eb);
            check($sformatf("vec%0d_hs", i), f_hs, vecs[i].hs);
            check($sformatf("vec%0d_vs", i), f_vs, vecs[i].vs);
        end

        // Exact two-clock alignment of colour and sync
        drive(1'b1, 1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 8'hFF, 8'hFF, 8'hFF);
        repeat (2) @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 10'd0, 10'd0, 8'h00, 8'h00, 8'h00);
        @(negedge clk);
        check("lat1_r",  f_r,  7);
        check("lat1_hs", f_hs, 1);
        @(negedge clk);
        check("lat2_r",  f_r,  0);
        check("lat2_hs", f_hs, 0);

        // Temporal rotation: two frames -> offset 2, B = BAYER[2][2] = 1
        vblank_pulse();
        vblank_pulse();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 8'h1E, 8'h00, 8'h00);
        repeat (2) @(negedge clk);
        check("temporal_ofs2_r", t_r, 1);
        check("fixed_ofs0_r",    f_r, 0);

        // Three more frames -> offset 1, B = BAYER[1][1] = 4
        vblank_pulse();
        vblank_pulse();
        vblank_pulse();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 8'h18, 8'h16, 8'h00);
        repeat (2) @(negedge clk);
        check("temporal_ofs1_r", t_r, 1);
        check("temporal_ofs1_g", t_g, 0);
        check("fixed_ofs1_r",    f_r, 0);

        // Mid-frame async reset while outputs are non-zero
        drive(1'b0, 1'b0, 1'b1, 1'b0, 10'd0, 10'd0, 8'hFF, 8'hFF, 8'hFF);
        repeat (2) @(negedge clk);
        check("pre_reset_r", t_r, 7);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_r",  t_r,  0);
        check("async_reset_g",  t_g,  0);
        check("async_reset_hs", t_hs, 1);
        check("async_reset_vs", t_vs, 1);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 10'd0, 10'd0, 8'hBF, 8'h00, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_1clk_r", t_r, 0);
        @(negedge clk);
        // offset cleared by reset: B = 0, so 0xBF -> 5 (offset 1 would give 6)
        check("post_reset_2clk_r",  t_r,  5);
        check("post_reset_2clk_hs", t_hs, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
